vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator and pixel output stage; successor to the fixed 640x480 controller.
- Timing (porches, sync widths, polarities) and the pixel-clock divider are parameters. The block exports the current pixel coordinate to the pixel source, registers returned colour together with the syncs, forces blanking outside the active area and emits frame/line strobes.
- Sits between the game renderer (pixel source) and the VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixel ticks)
- H_SYNC, 96, horizontal sync width (pixel ticks)
- H_BP, 48, horizontal back porch (pixel ticks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, HSYNC active level (0 = active-low)
- VS_POL, 0, VSYNC active level
- CLK_DIV, 2, clk cycles per pixel tick (>=1)
- COLOR_W, 8, bits per colour channel
- Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; XW = $clog2(H_TOTAL); YW = $clog2(V_TOTAL).

Ports:
- clk  in  1  system clock
- RST_BTN  in  1  reset, asynchronous, active-high
- en  in  1  run enable; low holds the raster idle
- pix_r, pix_g, pix_b  in  COLOR_W each  colour for current pix_x/pix_y
- pix_x  out  XW  current horizontal counter
- pix_y  out  YW  current vertical counter
- pix_active  out  1  pix_x < H_ACTIVE and pix_y < V_ACTIVE (combinational from counters)
- HSYNC, VSYNC  out  1  registered sync outputs
- VGA_R, VGA_G, VGA_B  out  COLOR_W each  registered colour, zero when blanked
- VGA_BLANK_N  out  1  registered, high in active area
- frame_start  out  1  one-clk pulse
- line_start  out  1  one-clk pulse

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, RST_BTN).
- Reset values:
  - div, hcnt, vcnt = 0
  - HSYNC = !HS_POL; VSYNC = !VS_POL
  - VGA_R/G/B = 0; VGA_BLANK_N = 0
  - frame_start = 0; line_start = 0
- Divider: div counts 0..CLK_DIV-1 while en. tick = en and (div == CLK_DIV-1). With CLK_DIV = 1, tick = en every cycle.
- Counters, on tick:
  - hcnt wraps H_TOTAL-1 -> 0.
  - On that wrap vcnt increments, or wraps V_TOTAL-1 -> 0.
- en low:
  - div, hcnt and vcnt are cleared on the next clk.
  - Registered outputs go to their reset values on the next clk.
  - Resuming en restarts at (0,0). There is no mid-frame resume.
- Output register, loaded on tick only and held between ticks; values are derived from the pre-increment hcnt/vcnt:
  - HSYNC = HS_POL when hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else !HS_POL.
  - VSYNC = VS_POL when vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (whole lines), else !VS_POL.
  - VGA_BLANK_N = pix_active.
  - VGA_R/G/B = pix_r/g/b if pix_active, else 0.
- Latency: colour presented for (x,y) appears on the VGA pins one tick later, aligned with that pixel's sync and blank. The pixel source must drive colour combinationally, or within the same tick period, from pix_x/pix_y.
- Strobes:
  - frame_start = 1 for exactly one clk, on the tick where hcnt == 0 and vcnt == 0.
  - line_start = 1 for one clk on every tick with hcnt == 0, including the frame-start tick.
- Width rule: counter comparisons are unsigned at XW/YW bits. Parameter sums must fit; violations are caught by an elaboration-time check.
- Reset mid-frame: all state clears immediately (asynchronous). The first tick after release occurs CLK_DIV clks later and starts at (0,0).

Test Plan:
- Default params, en = 1 from reset:
  - first frame_start on the first tick (clk 2)
  - line_start period 1600 clks
  - HSYNC low for 192 clks, starting 656 ticks after line start (+1 tick register delay)
- Default params, full frame:
  - frame_start period 840000 clks
  - VSYNC low for 2 lines = 3200 clks, beginning at line 490
  - VGA_BLANK_N high for 640 ticks per line on lines 0..479 only
- Small config (H 4/1/1/1, V 3/1/1/1, CLK_DIV = 1, HS_POL = VS_POL = 1), pix_r = pix_x:
  - VGA_R sequence 0,1,2,3,0,0,0 repeating, with one-tick lag
  - HSYNC high exactly on the tick following hcnt == 5
- en dropped at pix (100,50):
  - next clk has hcnt = vcnt = 0 and HSYNC/VSYNC inactive
  - on en re-assert, frame_start fires after CLK_DIV clks
- RST_BTN pulsed asynchronously mid-line (between clk edges):
  - outputs reach reset values immediately, without waiting for a clk edge
  - timing restarts cleanly after release
- Colour forced 0xFF during blanking (pix_x >= 640): VGA_R/G/B remain 0 and VGA_BLANK_N = 0.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the raster generator, the pixel source and the VGA DAC pins.
// master = timing generator side; slave = renderer / pin consumer side.
interface vga_timing_gen_if #(
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int COLOR_W = 8
);
  logic [XW-1:0]      pix_x;
  logic [YW-1:0]      pix_y;
  logic               pix_active;
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;
  logic               HSYNC;
  logic               VSYNC;
  logic [COLOR_W-1:0] VGA_R;
  logic [COLOR_W-1:0] VGA_G;
  logic [COLOR_W-1:0] VGA_B;
  logic               VGA_BLANK_N;
  logic               frame_start;
  logic               line_start;

  modport master (
    output pix_x, pix_y, pix_active,
    output HSYNC, VSYNC, VGA_R, VGA_G, VGA_B, VGA_BLANK_N,
    output frame_start, line_start,
    input  pix_r, pix_g, pix_b
  );

  modport slave (
    input  pix_x, pix_y, pix_active,
    input  HSYNC, VSYNC, VGA_R, VGA_G, VGA_B, VGA_BLANK_N,
    input  frame_start, line_start,
    output pix_r, pix_g, pix_b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a registered pixel output stage.
// Exports the current raster coordinate to the pixel source, registers the returned
// colour together with sync/blank one pixel tick later, and emits frame/line strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 2,
  parameter int COLOR_W  = 8
) (
  input logic              clk,
  input logic              RST_BTN,
  input logic              en,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  // Reject timings whose sums cannot be represented or that make no sense.
  if (CLK_DIV < 1 || H_ACTIVE < 1 || V_ACTIVE < 1 || H_SYNC < 1 || V_SYNC < 1 ||
      H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0 || H_TOTAL < 2 || V_TOTAL < 2 ||
      H_TOTAL > (1 << XW) || V_TOTAL > (1 << YW)) begin : g_param_check
    $error("vga_timing_gen: timing parameters out of range");
  end

  logic [DW-1:0]      div_q, div_d;
  logic [XW-1:0]      hcnt_q, hcnt_d;
  logic [YW-1:0]      vcnt_q, vcnt_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic [COLOR_W-1:0] r_q, r_d;
  logic [COLOR_W-1:0] g_q, g_d;
  logic [COLOR_W-1:0] b_q, b_d;
  logic               blank_n_q, blank_n_d;
  logic               frame_start_q, frame_start_d;
  logic               line_start_q, line_start_d;

  logic tick;
  logic active;
  logic h_last;
  logic v_last;
  logic hs_zone;
  logic vs_zone;

  assign tick    = en && (div_q == DIV_LAST);
  assign active  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign h_last  = (hcnt_q == H_LAST);
  assign v_last  = (vcnt_q == V_LAST);
  assign hs_zone = (hcnt_q >= HS_BEG) && (hcnt_q <= HS_END);
  assign vs_zone = (vcnt_q >= VS_BEG) && (vcnt_q <= VS_END);

  // Next-state: advance the raster on each pixel tick, idle everything while en is low.
  always_comb begin
    // NOTE: hold/idle defaults come first so every path assigns every _d signal (no latches).
    div_d         = div_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    blank_n_d     = blank_n_q;
    frame_start_d = 1'b0;
    line_start_d  = 1'b0;

    if (!en) begin
      // No mid-frame resume: dropping en parks the raster at (0,0) with idle pins.
      div_d     = '0;
      hcnt_d    = '0;
      vcnt_d    = '0;
      hsync_d   = ~HS_ON;
      vsync_d   = ~VS_ON;
      r_d       = '0;
      g_d       = '0;
      b_d       = '0;
      blank_n_d = 1'b0;
    end else begin
      div_d = tick ? '0 : div_q + DW'(1);
      if (tick) begin
        hcnt_d = h_last ? '0 : hcnt_q + XW'(1);
        if (h_last) begin
          vcnt_d = v_last ? '0 : vcnt_q + YW'(1);
        end
        // Pin values describe the pixel currently addressed (pre-increment counters).
        hsync_d       = hs_zone ? HS_ON : ~HS_ON;
        vsync_d       = vs_zone ? VS_ON : ~VS_ON;
        blank_n_d     = active;
        r_d           = active ? vga.pix_r : '0;
        g_d           = active ? vga.pix_g : '0;
        b_d           = active ? vga.pix_b : '0;
        frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
        line_start_d  = (hcnt_q == '0);
      end
    end
  end

  // State and output registers, cleared asynchronously by RST_BTN.
  always_ff @(posedge clk or posedge RST_BTN) begin
    if (RST_BTN) begin
      div_q         <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same pre-edge values.
      div_q         <= div_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
    end
  end

  assign vga.pix_x       = hcnt_q;
  assign vga.pix_y       = vcnt_q;
  assign vga.pix_active  = active;
  assign vga.HSYNC       = hsync_q;
  assign vga.VSYNC       = vsync_q;
  assign vga.VGA_R       = r_q;
  assign vga.VGA_G       = g_q;
  assign vga.VGA_B       = b_q;
  assign vga.VGA_BLANK_N = blank_n_q;
  assign vga.frame_start = frame_start_q;
  assign vga.line_start  = line_start_q;
endmodule
